// File: rtl/calendar_pkg.sv
// Shared definitions for the calendar display path.
//   - Active-low seven-segment codes, bit order {g,f,e,d,c,b,a}
//   - Digit count of the HH:MM:SS display
//   - Blink-select encodings, and the field that owns each digit slot
package calendar_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        BLINK_NONE    = 2'd0,
        BLINK_HOURS   = 2'd1,
        BLINK_MINUTES = 2'd2,
        BLINK_SECONDS = 2'd3
    } blink_sel_e;

    // Digits 0/1 are seconds, 2/3 minutes, 4/5 hours.
    function automatic blink_sel_e digit_field(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: digit_field = BLINK_SECONDS;
            3'd2, 3'd3: digit_field = BLINK_MINUTES;
            3'd4, 3'd5: digit_field = BLINK_HOURS;
            default:    digit_field = BLINK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
//   nib : 4-bit BCD digit
//   seg : {g,f,e,d,c,b,a}, active-low; non-BCD values (>9) show a dash
module bcd_to_7seg
    import calendar_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Six-digit multiplexed common-anode display scanner for HH:MM:SS.
//   CP, RSTn      : clock (rising), async active-low reset
//   En            : scan/blink advance enable
//   Hbcd/Mbcd/Sbcd: packed BCD {tens,units} time fields
//   BlinkSel      : field blinked during time-set (calendar_pkg encodings)
//   ColonEn       : light DP on digits 2 and 4
//   AN, SEG, DP   : active-low digit enables, segments {g..a}, decimal point
// Fields are snapshotted as the scan wraps to digit 0, so a frame never tears.
module bcd_display_scanner
    import calendar_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter bit LZB          = 1'b1
) (
    input  logic       CP,
    input  logic       RSTn,
    input  logic       En,
    input  logic [7:0] Hbcd,
    input  logic [7:0] Mbcd,
    input  logic [7:0] Sbcd,
    input  logic [1:0] BlinkSel,
    input  logic       ColonEn,
    output logic [5:0] AN,
    output logic [6:0] SEG,
    output logic       DP
);

    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [2:0]  LAST_IDX   = 3'(NUM_DIGITS - 1);

    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  snap_h_q, snap_h_d, snap_m_q, snap_m_d, snap_s_q, snap_s_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        hidden_q, hidden_d;
    logic [5:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic        advance, wrap;
    logic [2:0]  idx_n;
    logic [3:0]  nib;
    logic [6:0]  seg_dec;

    // Counters, snapshot and blink phase. The digit nibble is taken from the
    // *_d snapshot so digit 0 on a wrap edge decodes the values being captured.
    always_comb begin
        scan_cnt_d  = scan_cnt_q;
        idx_d       = idx_q;
        snap_h_d    = snap_h_q;
        snap_m_d    = snap_m_q;
        snap_s_d    = snap_s_q;
        frame_cnt_d = frame_cnt_q;
        hidden_d    = hidden_q;

        advance = En && (scan_cnt_q == SCAN_LAST);
        // Out-of-range indices (6, 7) recover like a normal frame wrap.
        wrap    = (idx_q >= LAST_IDX);
        idx_n   = wrap ? 3'd0 : 3'(idx_q + 3'd1);

        if (En)
            scan_cnt_d = advance ? 16'd0 : 16'(scan_cnt_q + 16'd1);

        if (advance) begin
            idx_d = idx_n;
            if (wrap) begin
                snap_h_d = Hbcd;
                snap_m_d = Mbcd;
                snap_s_d = Sbcd;
                if (frame_cnt_q >= FRAME_LAST) begin
                    frame_cnt_d = 8'd0;
                    hidden_d    = ~hidden_q;
                end else begin
                    frame_cnt_d = 8'(frame_cnt_q + 8'd1);
                end
            end
        end

        case (idx_n)
            3'd0:    nib = snap_s_d[3:0];
            3'd1:    nib = snap_s_d[7:4];
            3'd2:    nib = snap_m_d[3:0];
            3'd3:    nib = snap_m_d[7:4];
            3'd4:    nib = snap_h_d[3:0];
            default: nib = snap_h_d[7:4];
        endcase
    end

    bcd_to_7seg u_dec (
        .nib (nib),
        .seg (seg_dec)
    );

    // Output registers load only on the advance edge, for the new digit.
    always_comb begin
        logic blink_blank;
        logic lz_blank;

        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;

        // The new phase applies, so a toggle on a wrap edge affects digit 0.
        blink_blank = hidden_d && (BlinkSel != BLINK_NONE) &&
                      (BlinkSel == digit_field(idx_n));
        // A non-zero tens value (including invalid BCD) is never blanked.
        lz_blank    = LZB && (idx_n == LAST_IDX) && (snap_h_d[7:4] == 4'd0);

        if (advance) begin
            an_d  = ~(6'b000001 << idx_n);
            seg_d = (blink_blank || lz_blank) ? SEG_BLANK : seg_dec;
            dp_d  = ~(ColonEn && (idx_n == 3'd2 || idx_n == 3'd4) && !blink_blank);
        end
    end

    always_ff @(posedge CP or negedge RSTn) begin
        if (!RSTn) begin
            scan_cnt_q  <= 16'd0;
            idx_q       <= LAST_IDX;
            snap_h_q    <= 8'd0;
            snap_m_q    <= 8'd0;
            snap_s_q    <= 8'd0;
            frame_cnt_q <= 8'd0;
            hidden_q    <= 1'b0;
            an_q        <= 6'b111111;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            snap_h_q    <= snap_h_d;
            snap_m_q    <= snap_m_d;
            snap_s_q    <= snap_s_d;
            frame_cnt_q <= frame_cnt_d;
            hidden_q    <= hidden_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
module tb_bcd_display_scanner;

    localparam int SD = 4;
    localparam int BF = 2;

    logic       CP = 1'b0;
    logic       RSTn = 1'b0;
    logic       En = 1'b1;
    logic [7:0] Hbcd = 8'h12, Mbcd = 8'h34, Sbcd = 8'h56;
    logic [1:0] BlinkSel = 2'd0;
    logic       ColonEn = 1'b0;
    logic [5:0] an1, an0;
    logic [6:0] seg1, seg0;
    logic       dp1, dp0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CP = ~CP;

    bcd_display_scanner #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZB(1'b1)) dut1 (
        .CP(CP), .RSTn(RSTn), .En(En), .Hbcd(Hbcd), .Mbcd(Mbcd), .Sbcd(Sbcd),
        .BlinkSel(BlinkSel), .ColonEn(ColonEn), .AN(an1), .SEG(seg1), .DP(dp1));

    bcd_display_scanner #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZB(1'b0)) dut0 (
        .CP(CP), .RSTn(RSTn), .En(En), .Hbcd(Hbcd), .Mbcd(Mbcd), .Sbcd(Sbcd),
        .BlinkSel(BlinkSel), .ColonEn(ColonEn), .AN(an0), .SEG(seg0), .DP(dp0));

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0: seg7 = 7'b1000000;  4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;  4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;  4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;  4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;  4'd9: seg7 = 7'b0010000;
            default: seg7 = 7'b0111111;
        endcase
    endfunction

    // Expected {AN, SEG, DP} after advance number a (1-based since reset).
    // Digit = (a-1) mod 6; frame k = (a-1)/6 + 1; the phase is hidden when
    // k/BF is odd (toggles on every BF-th frame wrap).
    function automatic logic [13:0] model_out(input int a, input logic [7:0] h, m, s,
                                              input logic [1:0] bsel, input logic colon,
                                              input bit lzb);
        int idx, k;
        bit hidden, bl, lz;
        logic [3:0] nib;
        logic [6:0] sg;
        idx = (a - 1) % 6;
        k = (a - 1) / 6 + 1;
        hidden = ((k / BF) % 2) == 1;
        case (idx)
            0: nib = s[3:0];
            1: nib = s[7:4];
            2: nib = m[3:0];
            3: nib = m[7:4];
            4: nib = h[3:0];
            default: nib = h[7:4];
        endcase
        bl = hidden && (bsel != 2'd0) && (int'(bsel) == 3 - idx / 2);
        lz = lzb && (idx == 5) && (h[7:4] == 4'd0);
        sg = (bl || lz) ? 7'h7F : seg7(nib);
        return {~(6'(6'b000001 << idx)), sg, ~(colon && (idx == 2 || idx == 4) && !bl)};
    endfunction

    // Model state: enabled-cycle count since reset and the frame snapshot.
    int n_m = 0;
    logic [7:0] sh_m = 8'h0, sm_m = 8'h0, ss_m = 8'h0;
    logic [13:0] e1 = {6'h3F, 7'h7F, 1'b1};
    logic [13:0] e0 = {6'h3F, 7'h7F, 1'b1};

    always @(posedge CP or negedge RSTn) begin
        if (!RSTn) begin
            n_m  <= 0;
            sh_m <= 8'h0; sm_m <= 8'h0; ss_m <= 8'h0;
            e1   <= {6'h3F, 7'h7F, 1'b1};
            e0   <= {6'h3F, 7'h7F, 1'b1};
        end else if (En) begin
            n_m <= n_m + 1;
            if ((n_m + 1) % SD == 0) begin
                if ((((n_m + 1) / SD - 1) % 6) == 0) begin
                    sh_m <= Hbcd; sm_m <= Mbcd; ss_m <= Sbcd;
                    e1 <= model_out((n_m + 1) / SD, Hbcd, Mbcd, Sbcd, BlinkSel, ColonEn, 1'b1);
                    e0 <= model_out((n_m + 1) / SD, Hbcd, Mbcd, Sbcd, BlinkSel, ColonEn, 1'b0);
                end else begin
                    e1 <= model_out((n_m + 1) / SD, sh_m, sm_m, ss_m, BlinkSel, ColonEn, 1'b1);
                    e0 <= model_out((n_m + 1) / SD, sh_m, sm_m, ss_m, BlinkSel, ColonEn, 1'b0);
                end
            end
        end
    end

    always @(negedge CP) begin
        chk("an_lzb1",  {10'd0, an1},  {10'd0, e1[13:8]});
        chk("seg_lzb1", {9'd0, seg1},  {9'd0, e1[7:1]});
        chk("dp_lzb1",  {15'd0, dp1},  {15'd0, e1[0]});
        chk("an_lzb0",  {10'd0, an0},  {10'd0, e0[13:8]});
        chk("seg_lzb0", {9'd0, seg0},  {9'd0, e0[7:1]});
        chk("dp_lzb0",  {15'd0, dp0},  {15'd0, e0[0]});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CP);
        #1;
    endtask

    task automatic adv();
        cyc(SD);
    endtask

    // Hand-computed literal pins on the LZB=1 instance.
    task automatic lit(input string name, input logic [5:0] an, input logic [6:0] sg, input logic dp);
        chk({name, "_an"},  {10'd0, an1}, {10'd0, an});
        chk({name, "_seg"}, {9'd0, seg1}, {9'd0, sg});
        chk({name, "_dp"},  {15'd0, dp1}, {15'd0, dp});
    endtask

    logic [5:0] hold_an;
    logic [6:0] hold_seg;

    initial begin
        // Reset and first frame
        #22 RSTn = 1'b1;
        lit("rst", 6'b111111, 7'h7F, 1'b1);
        cyc(3);
        lit("pre_first", 6'b111111, 7'h7F, 1'b1);
        cyc(1);
        lit("f1_d0", 6'b111110, 7'b0000010, 1'b1);
        adv(); lit("f1_d1", 6'b111101, 7'b0010010, 1'b1);
        adv(); lit("f1_d2", 6'b111011, 7'b0011001, 1'b1);
        adv(); lit("f1_d3", 6'b110111, 7'b0110000, 1'b1);
        // Tear-free: change seconds mid-frame
        Sbcd = 8'h57;
        adv(); lit("f1_d4", 6'b101111, 7'b0100100, 1'b1);
        adv(); lit("f1_d5", 6'b011111, 7'b1111001, 1'b1);
        adv(); lit("f2_d0", 6'b111110, 7'b1111000, 1'b1);

        // Blink minutes, colon on, hours changes to 09 (visible next frame)
        BlinkSel = 2'd2; ColonEn = 1'b1; Hbcd = 8'h09;
        adv();
        adv(); lit("f2_d2_blink", 6'b111011, 7'h7F, 1'b1);
        adv(); lit("f2_d3_blink", 6'b110111, 7'h7F, 1'b1);
        adv(); lit("f2_d4_colon", 6'b101111, 7'b0100100, 1'b0);
        adv(); lit("f2_d5", 6'b011111, 7'b1111001, 1'b1);
        adv(); lit("f3_d0", 6'b111110, 7'b1111000, 1'b1);
        repeat (5) adv();
        lit("f3_d5_lzb", 6'b011111, 7'h7F, 1'b1);
        chk("f3_d5_nolzb_seg", {9'd0, seg0}, {9'd0, 7'b1000000});
        adv(); adv();
        adv(); lit("f4_d2_visible", 6'b111011, 7'b0011001, 1'b0);

        // Invalid BCD, then En gating
        Sbcd = 8'h5C;
        repeat (4) adv();
        lit("f5_d0_dash", 6'b111110, 7'b0111111, 1'b1);
        cyc(2);
        hold_an = an1; hold_seg = seg1;
        En = 1'b0;
        cyc(10);
        chk("en_hold_an",  {10'd0, an1}, {10'd0, hold_an});
        chk("en_hold_seg", {9'd0, seg1}, {9'd0, hold_seg});
        En = 1'b1;
        cyc(1); lit("resume_same", 6'b111110, 7'b0111111, 1'b1);
        cyc(1); lit("resume_adv", 6'b111101, 7'b0010010, 1'b1);

        // Mid-frame asynchronous reset at digit 3
        adv(); adv();
        #2 RSTn = 1'b0;
        #1 lit("async_rst", 6'b111111, 7'h7F, 1'b1);
        Sbcd = 8'h21; BlinkSel = 2'd0; ColonEn = 1'b0;
        cyc(1);
        RSTn = 1'b1;
        cyc(3); lit("post_rst_off", 6'b111111, 7'h7F, 1'b1);
        cyc(1); lit("post_rst_d0", 6'b111110, 7'b1111001, 1'b1);

        // Free run across blink selections for model coverage
        BlinkSel = 2'd3; ColonEn = 1'b1;
        repeat (30) adv();
        BlinkSel = 2'd1; Hbcd = 8'h23; Mbcd = 8'h59;
        repeat (30) adv();
        BlinkSel = 2'd0;
        repeat (12) adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Consumes the packed-BCD hour/minute/second fields produced by the calendar's modulo counters.
- Drives a 6-digit multiplexed common-anode seven-segment display, one digit at a time.
- Snapshots the fields once per scan frame so digits cannot tear; supports field blinking during time-set, hours leading-zero blanking and colon decimal points.
- Sits between the counter chain and the board pins.

Parameters:
- SCAN_DIV, 1000, CP cycles (with En high) per digit slot; legal range 2..65535.
- BLINK_FRAMES, 64, full scan frames per blink half-period; legal range 1..255.
- LZB, 1, 1 blanks the hours-tens digit when it is 0; 0 always shows it.

Ports:
- CP  input  1  system clock, rising edge.
- RSTn  input  1  reset, asynchronous, active-low.
- En  input  1  scan-advance enable; scan and blink counters hold when low.
- Hbcd  input  8  hours, {tens,units} BCD.
- Mbcd  input  8  minutes, {tens,units} BCD.
- Sbcd  input  8  seconds, {tens,units} BCD.
- BlinkSel  input  2  0 none, 1 hours, 2 minutes, 3 seconds.
- ColonEn  input  1  1 lights the DP on digits 2 and 4.
- AN  output  6  digit enables, active-low, one-hot-zero; bit0 = rightmost digit.
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point, active-low.

Behaviour:
- Reset (async, RSTn low): AN=6'b111111, SEG=7'h7F, DP=1, scan_cnt=0, digit index idx=5, snapshot registers=0, frame_cnt=0, blink phase=visible. All state registers take these values immediately, including mid-frame.
- Digit map by idx:
  - 0 = Sbcd[3:0], 1 = Sbcd[7:4]
  - 2 = Mbcd[3:0], 3 = Mbcd[7:4]
  - 4 = Hbcd[3:0], 5 = Hbcd[7:4]
- Scan counter:
  - When En=1, scan_cnt increments and wraps at SCAN_DIV-1. The wrap edge is the "advance edge".
  - When En=0, scan_cnt, idx and frame_cnt hold, and outputs hold their current values.
- Advance edge:
  - idx <= (idx==5) ? 0 : idx+1.
  - AN, SEG and DP are registered on the same edge for the new idx. There is no extra pipeline stage.
- Snapshot:
  - On an advance edge with idx 5->0, all three input fields are captured into snapshot registers.
  - Digit 0's outputs on that edge are decoded from the inputs being captured.
  - All other digits decode from the snapshot. Input changes mid-frame are never visible until the next frame.
- First frame: the first advance after reset wraps 5->0, so the display always begins with a fresh snapshot at digit 0. Outputs stay all-off until then.
- Segment decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble >9 = 0111111 (g only, dash).
- Blank digit: AN bit stays active but SEG=7'h7F and DP=1. Blanking conditions:
  - (a) blink phase = hidden and idx belongs to the BlinkSel field;
  - (b) LZB=1, idx=5 and snapshot hours tens==0. Tens > 9 is not blanked; it shows a dash.
- DP: 0 when ColonEn=1 and idx is 2 or 4, unless the digit is blanked by (a); otherwise 1.
- Blink:
  - frame_cnt increments on each 5->0 advance edge.
  - At BLINK_FRAMES-1 it wraps to 0 and toggles the phase; the first toggle goes visible->hidden.
  - BlinkSel=0 forces visible display but does not stop the phase counter.
  - A BlinkSel change takes effect at the next advance edge.
- Simultaneous events: a 5->0 wrap coinciding with a blink toggle uses the new phase for digit 0.
- Widths:
  - scan_cnt is 16 bits, compared against SCAN_DIV-1.
  - frame_cnt is 8 bits.
  - idx is 3 bits; values 6 and 7 are unreachable, and if entered they are forced to 0 on the next advance with the snapshot taken.

Decomposition:
- Shared package calendar_pkg:
  - Segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
  - NUM_DIGITS=6.
  - Blink-select encodings BLINK_NONE/HOURS/MINUTES/SECONDS.
- One combinational sub-module, bcd_to_7seg: 4-bit nibble in, 7-bit active-low SEG out, dash for values >9.
- The top holds the counters, snapshot, blink and output registers.

Test Plan:
- Reset and first frame: SCAN_DIV=4, En=1, Hbcd=8'h12, Mbcd=8'h34, Sbcd=8'h56, release RSTn -> outputs off for 4 cycles, then AN=111110/SEG=0000010 ('6'), every 4 cycles stepping through 5,4,3,2,1 with AN rotating 111101..011111.
- Tear-free: change Sbcd 8'h56->8'h57 while idx=3 -> digit 0 of the current frame unaffected; next frame digit 0 shows '7' (1111000).
- Blink: BLINK_FRAMES=2, BlinkSel=2 -> frames 0-1 show minutes; frames 2-3 show SEG=7F on idx 2 and 3 with AN still active; hours and seconds unaffected.
- Leading zero and colon: Hbcd=8'h09, LZB=1, ColonEn=1 -> idx5 blank; DP=0 only at idx 2 and 4; with LZB=0, idx5 shows '0' (1000000).
- Invalid BCD and En gating: Sbcd=8'h5C -> idx0 SEG=0111111. Drop En for 10 cycles -> AN, SEG and counters frozen; resume continues the count exactly.
- Reset mid-frame: assert RSTn low at idx=3 -> AN=111111, SEG=7F immediately (asynchronous); after release, the scan restarts at digit 0 with a fresh snapshot.
